// File: rtl/usb_vec_bridge_if.sv
// Byte-pipe bundle between usb_uart and usb_vec_bridge: host->FPGA (uart_out_*) and
// FPGA->host (uart_in_*) valid/ready streams.
interface usb_vec_bridge_if;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;

  // Host / usb_uart side
  modport master (
    output uart_out_data,
    output uart_out_valid,
    input  uart_out_ready,
    input  uart_in_data,
    input  uart_in_valid,
    output uart_in_ready
  );

  // Bridge side
  modport slave (
    input  uart_out_data,
    input  uart_out_valid,
    output uart_out_ready,
    output uart_in_data,
    output uart_in_valid,
    input  uart_in_ready
  );
endinterface

// File: rtl/usb_vec_bridge.sv
// Bridges usb_uart byte pipes to wide bit vectors: RX bit-writes into a shadow committed to vec_out,
// TX streams a vec_in snapshot as ASCII. `define USB_VEC_BRIDGE_HEX_EN selects hex TX encoding.
module usb_vec_bridge #(
  parameter int unsigned IN_W     = 64,
  parameter int unsigned OUT_W    = 64,
  parameter bit          FREE_RUN = 1'b1
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  usb_vec_bridge_if.slave      uart,
  output logic [IN_W-1:0]      vec_out,
  output logic                 vec_out_strobe,
  input  logic [OUT_W-1:0]     vec_in,
  input  logic                 tx_req,
  output logic                 tx_busy,
  output logic                 bad_idx
);

`ifdef USB_VEC_BRIDGE_HEX_EN
  localparam int unsigned NChars = (OUT_W + 3) / 4;
  localparam int unsigned PadW   = NChars * 4;
`else
  localparam int unsigned NChars = OUT_W;
`endif
  localparam int unsigned    CurW    = $clog2(NChars + 1);
  localparam logic [CurW-1:0] LastCur = CurW'(NChars);
  localparam logic [7:0]     InWLim  = 8'(IN_W);
  localparam logic [IN_W-1:0] OneIn  = IN_W'(1);
  localparam logic [7:0]     ChEnd   = 8'h2A;

  typedef enum logic [1:0] {StIdle, StSnap, StBits, StEnd} tx_state_e;

  // ---------------------------------------------------------------- RX path
  logic              rdy_q, rdy_d;
  logic [IN_W-1:0]   shadow_q, shadow_d;
  logic [IN_W-1:0]   vec_out_q, vec_out_d;
  logic              strobe_q, strobe_d;
  logic              bad_q, bad_d;
  logic              rx_fire;
  logic              rx_req;
  logic [6:0]        rx_idx;

  assign rx_fire = uart.uart_out_valid & rdy_q;
  assign rx_idx  = uart.uart_out_data[7:1];

  always_comb begin
    rdy_d     = 1'b1;
    shadow_d  = shadow_q;
    vec_out_d = vec_out_q;
    strobe_d  = 1'b0;
    bad_d     = bad_q;
    rx_req    = 1'b0;
    if (rx_fire) begin
      case (uart.uart_out_data)
        8'hFF: begin
          vec_out_d = shadow_q;
          strobe_d  = 1'b1;
        end
        8'hFE: begin
          shadow_d = '0;
          bad_d    = 1'b0;
        end
        8'hFD: rx_req = 1'b1;
        default: begin
          if ({1'b0, rx_idx} < InWLim) begin
            shadow_d = (shadow_q & ~(OneIn << rx_idx))
                     | (IN_W'(uart.uart_out_data[0]) << rx_idx);
          end else begin
            bad_d = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- TX path
  tx_state_e         state_q, state_d;
  logic [OUT_W-1:0]  snap_q, snap_d;
  logic [CurW-1:0]   cursor_q, cursor_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              pending_q, pending_d;
  logic              tx_fire;
  logic [7:0]        cur_char;

`ifdef USB_VEC_BRIDGE_HEX_EN
  logic [PadW-1:0]   padded;
  logic [PadW-1:0]   shifted;
  logic [CurW+1:0]   shamt;
  logic [3:0]        nib;

  // Cursor counts chars sent; nibbles go out MSB first.
  always_comb begin
    padded   = PadW'(snap_q);
    shamt    = {LastCur - CurW'(1) - cursor_q, 2'b00};
    shifted  = padded >> shamt;
    nib      = shifted[3:0];
    cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  end
`else
  logic [OUT_W-1:0]  bits_sh;

  always_comb begin
    bits_sh  = snap_q >> cursor_q;
    cur_char = {7'b0011000, bits_sh[0]};
  end
`endif

  assign tx_fire = valid_q & uart.uart_in_ready;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cursor_d  = cursor_q;
    data_d    = data_q;
    valid_d   = valid_q;
    pending_d = pending_q | rx_req | tx_req;
    unique case (state_q)
      StIdle: begin
        if (FREE_RUN || pending_q || tx_req) begin
          // Any request seen in this cycle is consumed by the frame being started.
          state_d   = StSnap;
          pending_d = 1'b0;
        end
      end
      StSnap: begin
        snap_d    = vec_in;
        cursor_d  = '0;
        pending_d = rx_req | tx_req;
        state_d   = StBits;
      end
      StBits: begin
        // !valid_q only on the first BITS cycle: preload char 0.
        if (!valid_q || tx_fire) begin
          valid_d = 1'b1;
          if (cursor_q == LastCur) begin
            data_d  = ChEnd;
            state_d = StEnd;
          end else begin
            data_d   = cur_char;
            cursor_d = cursor_q + CurW'(1);
          end
        end
      end
      StEnd: begin
        if (tx_fire) begin
          valid_d = 1'b0;
          state_d = FREE_RUN ? StSnap : StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      shadow_q  <= '0;
      vec_out_q <= '0;
      strobe_q  <= 1'b0;
      bad_q     <= 1'b0;
      state_q   <= StIdle;
      snap_q    <= '0;
      cursor_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      shadow_q  <= shadow_d;
      vec_out_q <= vec_out_d;
      strobe_q  <= strobe_d;
      bad_q     <= bad_d;
      state_q   <= state_d;
      snap_q    <= snap_d;
      cursor_q  <= cursor_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  assign uart.uart_out_ready = rdy_q;
  assign uart.uart_in_data   = data_q;
  assign uart.uart_in_valid  = valid_q;
  assign vec_out             = vec_out_q;
  assign vec_out_strobe      = strobe_q;
  assign bad_idx             = bad_q;
  assign tx_busy             = (state_q != StIdle);

endmodule
